cpu_seq: RTL and testbench
==========================

Name: cpu_seq

Overview:
Multi-cycle control sequencer for the dCPU core. It steps the fetch / execute / writeback datapath through FETCH, DECODE, EXEC, MEM and WB states, and shares a single memory port between instruction fetch and data access through a req/ack handshake. It generates the IR, PC and register-file write enables, and detects memory timeouts. Sits beside the datapath in the cpu top and replaces free-running single-cycle PC update.

Parameters:
OP_LD, 6'd16, opcode of load instruction (ins[31:26])
OP_ST, 6'd24, opcode of store instruction
OP_HALT, 6'd63, opcode of halt instruction
MAX_WAIT, 16, max cycles to wait for mem_ack per access; 0 = no timeout

Ports:
clk  input  1  system clock, rising edge
rstd  input  1  asynchronous reset, active-high
run  input  1  start/continue execution
ins_op  input  6  opcode from IR (ins[31:26]), valid from DECODE onward
mem_ack  input  1  memory access complete, one-cycle pulse or level
mem_req  output  1  memory access request
mem_sel  output  1  0 = instruction fetch, 1 = data access
mem_we  output  1  data write (store)
ir_we  output  1  load instruction register
pc_we  output  1  update PC to nextpc
rf_we  output  1  register-file write
state  output  3  current state encoding
busy  output  1  state not IDLE/HALT/ERR
halted  output  1  in HALT
err  output  1  in ERR (memory timeout)

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7; state register only sequential element besides wait counter.
- Reset (async, rstd=1): state=IDLE, wait_cnt=0; all outputs 0, state=0, for as long as rstd is high. Reset mid-access drops mem_req immediately; no completion.
- IDLE: run=1 -> FETCH next cycle; else stay.
- FETCH: mem_req=1, mem_sel=0. mem_ack=1 -> ir_we=1 same cycle (combinational), next DECODE.
- DECODE: 1 cycle. ins_op==OP_HALT -> HALT; else EXEC.
- EXEC: 1 cycle. ins_op==OP_LD or OP_ST -> MEM; else WB.
- MEM: mem_req=1, mem_sel=1, mem_we=(ins_op==OP_ST).
  - mem_ack on store: pc_we=1 same cycle; next FETCH if run=1, else IDLE.
  - mem_ack on load: next WB.
- WB: rf_we=1, pc_we=1 for exactly one cycle; next FETCH if run=1, else IDLE.
- HALT: halted=1, all enables 0; exit only by reset. run ignored.
- ERR: err=1, mem_req=0; exit only by reset.
- Wait counter: width $clog2(MAX_WAIT+1), min 1. Cleared on entry to FETCH/MEM and on ack; increments each FETCH/MEM cycle without ack.
  - Ack accepted in wait cycles 1..MAX_WAIT.
  - No ack by cycle MAX_WAIT -> ERR next cycle.
  - MAX_WAIT=0: wait indefinitely.
- Ack and timeout in same cycle: ack wins.
- mem_ack outside FETCH/MEM is ignored.
- Instruction latency with zero-wait memory: ALU 4 cycles, load 5, store 4.
- busy=1 in FETCH..WB.

Optional Feature:
Macro CPU_SEQ_PERF_EN. Defined: adds outputs instret[31:0] and cycles[31:0], both reset to 0 by rstd.
- instret increments on each pc_we pulse.
- cycles increments every cycle busy=1.
- Both wrap modulo 2^32.
Undefined: ports and counters absent; all other behaviour is identical.

Test Plan:
1. Reset, run=1, ins_op=0, ack in first FETCH cycle -> states 1,2,3,5; ir_we at cycle 1, rf_we=pc_we=1 only in WB; FETCH again at cycle 5.
2. ins_op=OP_LD, mem ack delayed 2 cycles in MEM -> MEM held 3 cycles with mem_sel=1, mem_we=0; then WB with rf_we=1; total 7 cycles.
3. ins_op=OP_ST -> mem_we=1 during MEM; pc_we coincident with ack; rf_we never asserted.
4. MAX_WAIT=4, mem_ack held 0 in FETCH -> 4 FETCH cycles, then state=7, err=1, mem_req=0 until reset.
5. ins_op=OP_HALT -> state 6, halted=1; toggling run has no effect; rstd pulse returns state=0.
6. rstd asserted asynchronously mid-MEM -> mem_req/mem_we drop before next clk edge; after release with run=1, FETCH follows. With CPU_SEQ_PERF_EN: instret=0, cycles=0 after reset.

Source files
------------

// File: rtl/cpu_seq_if.sv
// -----------------------------------------------------------------------------
// cpu_seq_if -- shared memory-port handshake between the dCPU sequencer and
// the memory / bus arbiter.
//
// Signals:
//   mem_req  sequencer -> memory  access request
//   mem_sel  sequencer -> memory  0 = instruction fetch, 1 = data access
//   mem_we   sequencer -> memory  data write (store)
//   mem_ack  memory -> sequencer  access complete (pulse or level)
//
// Modports:
//   master  the sequencer side (drives req/sel/we, samples ack)
//   slave   the memory side    (samples req/sel/we, drives ack)
// -----------------------------------------------------------------------------
interface cpu_seq_if;
    logic mem_req;
    logic mem_sel;
    logic mem_we;
    logic mem_ack;

    modport master (output mem_req, output mem_sel, output mem_we, input mem_ack);
    modport slave  (input mem_req, input mem_sel, input mem_we, output mem_ack);
endinterface

// File: rtl/cpu_seq.sv
// -----------------------------------------------------------------------------
// cpu_seq -- multi-cycle control sequencer for the dCPU core.
//
// Steps the datapath through FETCH / DECODE / EXEC / MEM / WB and shares one
// memory port between instruction fetch and data access. A wait counter
// bounds each memory access; an access not acknowledged within MAX_WAIT
// cycles parks the sequencer in ERR until reset.
//
// Parameters:
//   OP_LD, OP_ST, OP_HALT  opcodes (ins[31:26]) of load, store and halt
//   MAX_WAIT               cycles allowed per memory access, 0 = unbounded
//
// Ports:
//   clk      in   rising-edge clock
//   rstd     in   asynchronous reset, active-high
//   run      in   start / continue execution
//   ins_op   in   opcode from IR, valid from DECODE onward
//   bus      if   memory handshake (cpu_seq_if.master)
//   ir_we    out  load instruction register
//   pc_we    out  update PC to nextpc
//   rf_we    out  register-file write
//   state    out  current state encoding
//   busy     out  state is one of FETCH..WB
//   halted   out  in HALT
//   err      out  in ERR (memory timeout)
//   instret  out  retired-instruction counter  (only with CPU_SEQ_PERF_EN)
//   cycles   out  busy-cycle counter           (only with CPU_SEQ_PERF_EN)
//
// Optional feature: define CPU_SEQ_PERF_EN to add the instret / cycles
// performance counters. Without it those ports and counters do not exist.
// -----------------------------------------------------------------------------
module cpu_seq #(
    parameter logic [5:0] OP_LD    = 6'd16,
    parameter logic [5:0] OP_ST    = 6'd24,
    parameter logic [5:0] OP_HALT  = 6'd63,
    parameter int         MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rstd,
    input  logic        run,
    input  logic [5:0]  ins_op,
    cpu_seq_if.master   bus,
    output logic        ir_we,
    output logic        pc_we,
    output logic        rf_we,
    output logic [2:0]  state,
    output logic        busy,
    output logic        halted,
    output logic        err
`ifdef CPU_SEQ_PERF_EN
    ,
    output logic [31:0] instret,
    output logic [31:0] cycles
`endif
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] MEM    = 3'd4;
    localparam logic [2:0] WB     = 3'd5;
    localparam logic [2:0] HALT   = 3'd6;
    localparam logic [2:0] ERR    = 3'd7;

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    // Counter value seen in the last cycle an ack is still accepted: the
    // counter reads 0 in the first access cycle, so cycle MAX_WAIT reads
    // MAX_WAIT-1.
    localparam logic [WAIT_W-1:0] LAST_WAIT =
        (MAX_WAIT == 0) ? '0 : WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]        next_state;
    logic              ack;
    logic              in_access;
    logic              is_ld;
    logic              is_st;
    logic              timeout;

    assign ack       = bus.mem_ack;
    assign in_access = (state == FETCH) || (state == MEM);
    assign is_ld     = (ins_op == OP_LD);
    assign is_st     = (ins_op == OP_ST);
    // Only meaningful while in_access; an ack in the same cycle takes priority.
    assign timeout   = (MAX_WAIT != 0) && (wait_cnt == LAST_WAIT);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        next_state = state;
        case (state)
            IDLE:    if (run) next_state = FETCH;
            FETCH: begin
                if (ack)          next_state = DECODE;
                else if (timeout) next_state = ERR;
            end
            DECODE:  next_state = (ins_op == OP_HALT) ? HALT : EXEC;
            EXEC:    next_state = (is_ld || is_st) ? MEM : WB;
            MEM: begin
                if (ack)          next_state = is_st ? (run ? FETCH : IDLE) : WB;
                else if (timeout) next_state = ERR;
            end
            WB:      next_state = run ? FETCH : IDLE;
            HALT:    next_state = HALT;
            ERR:     next_state = ERR;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) state <= IDLE;
        else      state <= next_state;
    end

    // Counts unacknowledged cycles of the current access; any exit from the
    // access (ack or timeout) and every non-access state leave it at zero,
    // so each FETCH/MEM stint starts counting from zero.
    always_ff @(posedge clk or posedge rstd) begin
        if (rstd)
            wait_cnt <= '0;
        else if (in_access && !ack && !timeout && (MAX_WAIT != 0))
            wait_cnt <= wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end

    // Outputs decode from state alone, except the ack-qualified strobes;
    // reset forces state to IDLE asynchronously, so everything drops at once.
    always_comb begin
        bus.mem_req = in_access;
        bus.mem_sel = (state == MEM);
        bus.mem_we  = (state == MEM) && is_st;
        ir_we       = (state == FETCH) && ack;
        rf_we       = (state == WB);
        pc_we       = (state == WB) || ((state == MEM) && is_st && ack);
        busy        = (state >= FETCH) && (state <= WB);
        halted      = (state == HALT);
        err         = (state == ERR);
    end

`ifdef CPU_SEQ_PERF_EN
    always_ff @(posedge clk or posedge rstd) begin
        if (rstd) begin
            instret <= '0;
            cycles  <= '0;
        end else begin
            instret <= instret + {31'd0, pc_we};
            cycles  <= cycles + {31'd0, busy};
        end
    end
`endif

endmodule

// File: tb/tb_cpu_seq.sv
// -----------------------------------------------------------------------------
// tb_cpu_seq -- self-checking bench for cpu_seq (MAX_WAIT = 4).
//
// Each instruction is expanded into a per-cycle phase trace from its opcode
// and the number of wait cycles given to fetch and data access. Every traced
// cycle is queued with the outputs that phase must show; a negedge process
// pops and compares. Literal checks pin trace lengths, reset, halt, timeout
// and (with CPU_SEQ_PERF_EN) the counters.
// -----------------------------------------------------------------------------
module tb_cpu_seq;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_OR   = 6'd5;
    localparam logic [5:0] OP_LD   = 6'd16;
    localparam logic [5:0] OP_ST   = 6'd24;
    localparam logic [5:0] OP_HALT = 6'd63;
    localparam int         MAX_WAIT = 4;

    typedef enum logic [2:0] {
        P_IDLE = 3'd0, P_FETCH = 3'd1, P_DECODE = 3'd2, P_EXEC = 3'd3,
        P_MEM = 3'd4, P_WB = 3'd5, P_HALT = 3'd6, P_ERR = 3'd7
    } phase_t;

    typedef struct packed {
        logic [2:0] state;
        logic mem_req, mem_sel, mem_we, ir_we, pc_we, rf_we, busy, halted, err;
    } outs_t;

    typedef struct packed {
        outs_t       o;
        logic [31:0] instret;
        logic [31:0] cycles;
    } exp_t;

    typedef struct {
        phase_t ph;
        bit     ack;
    } slot_t;

    logic       clk;
    logic       rstd;
    logic       run;
    logic [5:0] ins_op;
    logic       ir_we, pc_we, rf_we, busy, halted, err;
    logic [2:0] state;
`ifdef CPU_SEQ_PERF_EN
    logic [31:0] instret, cycles;
`endif

    cpu_seq_if bus ();

    cpu_seq #(
        .OP_LD(OP_LD), .OP_ST(OP_ST), .OP_HALT(OP_HALT), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rstd(rstd), .run(run), .ins_op(ins_op), .bus(bus),
        .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .state(state),
        .busy(busy), .halted(halted), .err(err)
`ifdef CPU_SEQ_PERF_EN
        , .instret(instret), .cycles(cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    exp_t        exp_q[$];
    slot_t       trace[$];
    logic [31:0] m_instret = '0;
    logic [31:0] m_cycles  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Outputs a cycle in a given phase must show, straight from the phase rules.
    function automatic outs_t mk(input phase_t ph, input bit ack, input logic [5:0] op);
        outs_t o;
        o         = '0;
        o.state   = ph;
        o.busy    = ph inside {P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB};
        o.halted  = (ph == P_HALT);
        o.err     = (ph == P_ERR);
        o.mem_req = (ph == P_FETCH) || (ph == P_MEM);
        o.mem_sel = (ph == P_MEM);
        o.mem_we  = (ph == P_MEM) && (op == OP_ST);
        o.ir_we   = (ph == P_FETCH) && ack;
        o.rf_we   = (ph == P_WB);
        o.pc_we   = (ph == P_WB) || ((ph == P_MEM) && (op == OP_ST) && ack);
        return o;
    endfunction

    // Phase sequence of one instruction: fw / mw extra wait cycles before the
    // fetch / data ack.
    function automatic void build_trace(input logic [5:0] op, input int fw, input int mw);
        trace.delete();
        for (int i = 0; i <= fw; i++) trace.push_back('{P_FETCH, (i == fw)});
        trace.push_back('{P_DECODE, 1'b0});
        if (op == OP_HALT) return;
        trace.push_back('{P_EXEC, 1'b0});
        if (op == OP_LD || op == OP_ST)
            for (int i = 0; i <= mw; i++) trace.push_back('{P_MEM, (i == mw)});
        if (op != OP_ST) trace.push_back('{P_WB, 1'b0});
    endfunction

    // One clock cycle: drive inputs just after the edge and queue what the
    // DUT must show for the rest of the cycle.
    task automatic step(input phase_t ph, input bit ack, input logic [5:0] op, input bit r);
        exp_t e;
        @(posedge clk);
        #1;
        bus.mem_ack = ack;
        ins_op      = op;
        run         = r;
        e.o       = mk(ph, ack, op);
        e.instret = m_instret;
        e.cycles  = m_cycles;
        m_instret = m_instret + {31'd0, e.o.pc_we};
        m_cycles  = m_cycles + {31'd0, e.o.busy};
        exp_q.push_back(e);
    endtask

    // Runs one instruction; ack_noise drives mem_ack high in phases that must
    // ignore it, and ins_op carries a stale HALT opcode during FETCH.
    task automatic exec_instr(input logic [5:0] op, input int fw, input int mw,
                              input bit run_last, input bit ack_noise);
        build_trace(op, fw, mw);
        for (int i = 0; i < trace.size(); i++) begin
            bit         a;
            logic [5:0] opd;
            a   = (trace[i].ph == P_FETCH || trace[i].ph == P_MEM) ? trace[i].ack : ack_noise;
            opd = (trace[i].ph == P_FETCH) ? OP_HALT : op;
            step(trace[i].ph, a, opd, (i == trace.size() - 1) ? run_last : 1'b1);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstd = 1'b1;
        run = 1'b0;
        bus.mem_ack = 1'b0;
        ins_op = '0;
        m_instret = '0;
        m_cycles = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", state, 3'd0);
        check("reset_outs", {bus.mem_req, bus.mem_sel, bus.mem_we, ir_we, pc_we,
                             rf_we, busy, halted, err}, '0);
`ifdef CPU_SEQ_PERF_EN
        check("reset_instret", instret, 32'd0);
        check("reset_cycles", cycles, 32'd0);
`endif
        rstd = 1'b0;
    endtask

    // Compare process: one queued expectation per traced cycle.
    always @(negedge clk) begin
        exp_t  e;
        outs_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, bus.mem_req, bus.mem_sel, bus.mem_we, ir_we, pc_we,
                 rf_we, busy, halted, err};
            check("cycle_outs", 64'(a), 64'(e.o));
`ifdef CPU_SEQ_PERF_EN
            check("cycle_instret", instret, e.instret);
            check("cycle_cycles", cycles, e.cycles);
`endif
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstd = 1'b1;
        run = 1'b0;
        ins_op = '0;
        bus.mem_ack = 1'b0;

        // Model pins: zero-wait latencies ALU 4, load 5, store 4; load with two
        // data wait cycles 7; halt stops after DECODE.
        build_trace(OP_ADD, 0, 0);  check("len_alu", trace.size(), 4);
        check("alu_last_wb", trace[3].ph, P_WB);
        build_trace(OP_LD, 0, 0);   check("len_ld", trace.size(), 5);
        build_trace(OP_ST, 0, 0);   check("len_st", trace.size(), 4);
        check("st_last_mem", trace[3].ph, P_MEM);
        build_trace(OP_LD, 0, 2);   check("len_ld_w2", trace.size(), 7);
        build_trace(OP_HALT, 0, 0); check("len_halt", trace.size(), 2);

        // ALU, load with delayed ack, store, then wait-count boundaries.
        do_reset();
        step(P_IDLE, 1'b0, OP_ADD, 1'b1);
        exec_instr(OP_ADD, 0, 0, 1'b1, 1'b1);
        exec_instr(OP_LD, 0, 2, 1'b1, 1'b0);
        exec_instr(OP_ST, 1, 0, 1'b1, 1'b1);
        exec_instr(OP_OR, MAX_WAIT - 1, 0, 1'b1, 1'b0);
        exec_instr(OP_LD, 1, MAX_WAIT - 1, 1'b1, 1'b1);
        exec_instr(OP_ST, 0, MAX_WAIT - 1, 1'b0, 1'b0);
        step(P_IDLE, 1'b1, OP_ADD, 1'b0);
        step(P_IDLE, 1'b0, OP_ADD, 1'b1);
        exec_instr(OP_ADD, 0, 0, 1'b0, 1'b0);
        step(P_IDLE, 1'b0, OP_ADD, 1'b0);

        // Fetch timeout: four unacknowledged FETCH cycles, then ERR for good.
        do_reset();
        step(P_IDLE, 1'b0, OP_ADD, 1'b1);
        for (int i = 0; i < MAX_WAIT; i++) step(P_FETCH, 1'b0, OP_ADD, 1'b1);
        for (int i = 0; i < 3; i++) step(P_ERR, 1'b1, OP_ADD, i[0]);
        #2;
        check("timeout_state", state, 3'd7);
        check("timeout_err", err, 1'b1);
        check("timeout_req", bus.mem_req, 1'b0);

        // Halt: run toggles and stray acks do nothing until reset.
        do_reset();
        step(P_IDLE, 1'b0, OP_ADD, 1'b1);
        exec_instr(OP_HALT, 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(P_HALT, i[1], OP_HALT, i[0]);
        #2;
        check("halt_state", state, 3'd6);
        check("halt_flag", halted, 1'b1);

        // Asynchronous reset in the middle of a store's data access.
        do_reset();
        step(P_IDLE, 1'b0, OP_ADD, 1'b1);
        step(P_FETCH, 1'b1, OP_HALT, 1'b1);
        step(P_DECODE, 1'b0, OP_ST, 1'b1);
        step(P_EXEC, 1'b0, OP_ST, 1'b1);
        step(P_MEM, 1'b0, OP_ST, 1'b1);
        @(negedge clk);
        #1;
        rstd = 1'b1;
        #1;
        check("async_req", bus.mem_req, 1'b0);
        check("async_we", bus.mem_we, 1'b0);
        check("async_state", state, 3'd0);
        m_instret = '0;
        m_cycles = '0;
        @(posedge clk);
        #1;
        run = 1'b0;
        bus.mem_ack = 1'b0;
`ifdef CPU_SEQ_PERF_EN
        check("async_instret", instret, 32'd0);
        check("async_cycles", cycles, 32'd0);
`endif
        rstd = 1'b0;
        step(P_IDLE, 1'b0, OP_ADD, 1'b1);
        exec_instr(OP_ADD, 0, 0, 1'b0, 1'b0);
        step(P_IDLE, 1'b0, OP_ADD, 1'b0);
`ifdef CPU_SEQ_PERF_EN
        #2;
        check("perf_instret_1", instret, 32'd1);
        check("perf_cycles_4", cycles, 32'd4);
`endif

        @(posedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
